// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, ALU and load write ports, and a load scoreboard.
// Latency: reads 0 cycles (with write bypass); writes and busy/pend_cnt updates 1 edge.
// Backpressure: none internally; decode stalls on busy1/busy2 for outstanding loads.
//
// Ports: AD1/AD2 -> RD1/RD2, busy1/busy2 (read side); AD3/WE3/WD3 (ALU write);
// AD4/WE4/WD4 (load writeback, clears busy); issue_vld/issue_rd (sets busy);
// busy_any/pend_cnt (registered scoreboard summary); a0 (stored A0_INDEX value).
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic [ADDRESS_WIDTH-1:0] AD4,
  input  logic                     WE4,
  input  logic [DATA_WIDTH-1:0]    WD4,
  input  logic                     issue_vld,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  output logic                     busy_any,
  output logic [ADDRESS_WIDTH:0]   pend_cnt,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = A0_INDEX[ADDRESS_WIDTH-1:0];

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       busy_nxt;
  logic [ADDRESS_WIDTH:0] cnt_nxt;

  logic we3_ok;
  logic we4_ok;
  assign we3_ok = WE3 && (AD3 != '0);
  assign we4_ok = WE4 && (AD4 != '0);

  // Storage. Entry 0 is never written, so it stays zero after reset.
  // Port 4 is assigned last so a load writeback wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we3_ok) mem[AD3] <= WD3;
      if (we4_ok) mem[AD4] <= WD4;
    end
  end

  // Next busy vector: writeback clears first, then issue sets, so a new
  // load to the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (we4_ok) busy_nxt[AD4] = 1'b0;
    if (issue_vld && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDRESS_WIDTH{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
      busy_any <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
      busy_any <= |busy_nxt;
    end
  end

  // Read ports with same-cycle bypass; port 4 takes precedence over port 3.
  always_comb begin
    RD1 = mem[AD1];
    if (AD1 != '0) begin
      if (WE4 && (AD4 == AD1))      RD1 = WD4;
      else if (WE3 && (AD3 == AD1)) RD1 = WD3;
    end
  end

  always_comb begin
    RD2 = mem[AD2];
    if (AD2 != '0) begin
      if (WE4 && (AD4 == AD2))      RD2 = WD4;
      else if (WE3 && (AD3 == AD2)) RD2 = WD3;
    end
  end

  // A writeback landing this cycle resolves the hazard; its data is bypassed.
  assign busy1 = busy[AD1] & ~(WE4 && (AD4 == AD1));
  assign busy2 = busy[AD2] & ~(WE4 && (AD4 == AD2));

  assign a0 = mem[A0_ADDR];

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised dual-write-port integer register file with a load-writeback scoreboard for the reduced RISC-V core. Two asynchronous read ports serve decode. Write port 3 takes ALU results and write port 4 takes late load results. Register 0 is hardwired to zero, same-cycle writes are bypassed to the read ports, and a per-register busy bit tracks outstanding loads so decode can stall on a read-after-write hazard. Register 10 (a0) is exported for the top-level display.

## Interface
- ADDRESS_WIDTH, 5, register address width; depth = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register data width
- A0_INDEX, 10, register index exported on a0

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- AD1  in  ADDRESS_WIDTH  read port 1 address
- AD2  in  ADDRESS_WIDTH  read port 2 address
- RD1  out  DATA_WIDTH  read port 1 data (combinational)
- RD2  out  DATA_WIDTH  read port 2 data (combinational)
- busy1  out  1  register at AD1 has an outstanding load
- busy2  out  1  register at AD2 has an outstanding load
- AD3  in  ADDRESS_WIDTH  ALU write address
- WE3  in  1  ALU write enable
- WD3  in  DATA_WIDTH  ALU write data
- AD4  in  ADDRESS_WIDTH  load writeback address
- WE4  in  1  load writeback enable; also clears the busy bit of AD4
- WD4  in  DATA_WIDTH  load writeback data
- issue_vld  in  1  a load is issued this cycle
- issue_rd  in  ADDRESS_WIDTH  destination register of the issued load
- busy_any  out  1  at least one busy bit is set (registered)
- pend_cnt  out  ADDRESS_WIDTH+1  number of set busy bits (registered)
- a0  out  DATA_WIDTH  stored value of register A0_INDEX (no bypass)

## Operation
- Storage: 2**ADDRESS_WIDTH × DATA_WIDTH array, plus a busy vector of the same depth.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 on either port are dropped.
  - busy[0] is never set; busy for address 0 reads as 0.
- Write priority: if WE3 and WE4 target the same nonzero address in one cycle, WD4 is stored and WD3 is discarded.
- Read bypass, per port, combinational:
  - If WE4 is set, AD4 equals ADn and ADn is nonzero, RDn = WD4.
  - Otherwise, if WE3 is set, AD3 equals ADn and ADn is nonzero, RDn = WD3.
  - Otherwise, RDn is the stored value.
- Scoreboard update at each rising edge, in this order:
  - WE4 with AD4 nonzero clears busy[AD4].
  - Then issue_vld with issue_rd nonzero sets busy[issue_rd].
  - Issue therefore wins a same-cycle collision on the same address; the register stays busy for the new load.
- busyN = busy[ADN] AND NOT (WE4 AND AD4 == ADN). A writeback in the same cycle releases the hazard, and the bypassed WD4 is valid.
- WE3 never touches busy bits. An ALU write to a busy register updates data, but the register stays busy until its WE4 arrives.
- pend_cnt and busy_any are recomputed from the next busy vector and registered with it.
  - Issuing to an already-busy register does not increment the count.
  - The count saturates naturally at 2**ADDRESS_WIDTH-1, because register 0 is excluded.
- a0 = stored array[A0_INDEX], combinational from storage.

## Timing
- Reset (rst_n low, asynchronous):
  - All registers, busy bits, pend_cnt and busy_any go to 0 immediately.
  - RD1, RD2 and a0 read 0 unless a write is currently bypassing.
  - Deassertion is sampled by clk; the first write is accepted at the first rising edge with rst_n high.
- Reset mid-operation discards outstanding busy bits. Any later WE4 to a non-busy register still writes data and clears nothing.
- Read latency is 0 cycles: RDn and busyN follow ADn and the write inputs combinationally in the same cycle.
- Write latency is 1 edge: the stored value, and therefore a0, updates at the rising edge after WE is sampled.
- Scoreboard latency: busyN for a load issued in cycle t is first asserted in cycle t+1.
- Counters: pend_cnt and busy_any change at the same edge as the busy vector.

## Test plan
- Reset:
  - Stimulus: write 0x1234 to r5, then pulse rst_n low between edges.
  - Response: r5 reads 0 at once, pend_cnt = 0, a0 = 0.
- Register 0 and write collision:
  - Stimulus: WE3 with AD3 = 0, WD3 = 0xFFFFFFFF; then WE3 and WE4 both to r7 with WD3 = 0xAAAA, WD4 = 0x5555.
  - Response: r0 reads 0; r7 reads 0x5555 next cycle.
- Bypass:
  - Stimulus: WE3 to r10 with 0xCAFE, AD1 = 10, in the same cycle.
  - Response: RD1 = 0xCAFE that cycle, a0 = 0 that cycle and 0xCAFE after the edge.
- Scoreboard:
  - Stimulus: issue r3 at t, hold AD2 = 3, then WE4 to r3 with 0x77 at t+3.
  - Response: busy2 = 1 at t+1 and t+2; busy2 = 0 with RD2 = 0x77 at t+3; pend_cnt goes 1 then 0.
- Issue/writeback collision and duplicate issue:
  - Stimulus: issue r4 twice in consecutive cycles, then WE4 to r4 and issue r4 in the same cycle.
  - Response: pend_cnt stays 1 throughout, and r4 is still busy afterwards.
